ila_dump_ctrl: RTL

Readout sequencer for ila_core. On a start pulse it snapshots the sample count, walks ila_core's index and value_select over every captured sample and word, and emits each DATA_W word on a valid/ready stream with last on the final beat. It optionally pulses ila_core's rst_soft afterwards to re-arm capture. It sits between ila_core's software-access ports and a DMA or UART drain.

---
 rtl/ila_dump_ctrl_if.sv | 13 +
 rtl/ila_dump_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ila_dump_ctrl_if.sv
// Output stream of the ILA dump sequencer: one DATA_W word per beat,
// valid/ready handshake, last on the final beat of a dump.
interface ila_dump_ctrl_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/ila_dump_ctrl.sv
// Readout sequencer for ila_core: walks index/value_select over every
// captured word, streams them out, and optionally re-arms capture.
module ila_dump_ctrl #(
  parameter  int DATA_W   = 32,
  parameter  int BUFFER_W = 8,
  parameter  int SIGNAL_W = 8,
  parameter  int READ_LAT = 1,
  localparam int N_WORDS  = (SIGNAL_W + DATA_W - 1) / DATA_W,
  localparam int SEL_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                clear_en,
  output logic                busy,
  output logic                done,
  input  logic [DATA_W-1:0]   ila_samples,
  output logic [BUFFER_W-1:0] ila_index,
  output logic [SEL_W-1:0]    ila_value_select,
  input  logic [DATA_W-1:0]   ila_value,
  output logic                ila_rst_soft,
  ila_dump_ctrl_if.master     out_if
);

  localparam int CNT_W = BUFFER_W + 1;
  localparam logic [CNT_W-1:0] DEPTH   = {1'b1, {BUFFER_W{1'b0}}};
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_WORDS - 1);
  localparam logic [1:0]       LAT_MAX = 2'(READ_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT,
    S_OUT,
    S_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                clr_q, clr_d;
  logic [BUFFER_W-1:0] idx_q, idx_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [1:0]          wait_q, wait_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                vld_q, vld_d;
  logic                last_q, last_d;

  logic is_last;
  logic hs;

  // Position of the word currently addressed is the final word of the dump.
  assign is_last = ({1'b0, idx_q} == (cnt_q - 1'b1)) && (sel_q == SEL_MAX);
  assign hs      = vld_q && out_if.out_ready;

  // Next-state and datapath updates for the dump walk.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_d   = clr_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    wait_d  = wait_q;
    data_d  = data_q;
    vld_d   = vld_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          clr_d   = clear_en;
          // Saturate to buffer depth; the count is frozen for the whole dump.
          if (ila_samples > DATA_W'(DEPTH)) cnt_d = DEPTH;
          else                              cnt_d = ila_samples[CNT_W-1:0];
        end
      end
      S_SETUP: begin
        if (abort || cnt_q == '0) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = '0;
          sel_d   = '0;
          wait_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_FINISH;
        end else if (wait_q == LAT_MAX) begin
          data_d  = ila_value;
          vld_d   = 1'b1;
          last_d  = is_last;
          state_d = S_OUT;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_OUT: begin
        if (abort) begin
          // Beat is dropped whether or not it was accepted this cycle.
          vld_d   = 1'b0;
          last_d  = 1'b0;
          state_d = S_FINISH;
        end else if (hs) begin
          vld_d  = 1'b0;
          last_d = 1'b0;
          if (last_q) begin
            state_d = S_FINISH;
          end else begin
            if (sel_q == SEL_MAX) begin
              sel_d = '0;
              idx_d = idx_q + 1'b1;
            end else begin
              sel_d = sel_q + 1'b1;
            end
            wait_d  = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      clr_q   <= 1'b0;
      idx_q   <= '0;
      sel_q   <= '0;
      wait_q  <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_FINISH);
  assign ila_rst_soft     = (state_q == S_FINISH) && clr_q;
  assign ila_index        = idx_q;
  assign ila_value_select = sel_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_valid = vld_q;
  assign out_if.out_last  = last_q;

endmodule
